// File: rtl/audio_codec_i2s_if.sv
// rtl/audio_codec_i2s_if.sv - parallel sample bus between audio stage and I2S serializer
interface audio_codec_i2s_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_in_l;
    logic [SAMPLE_WIDTH-1:0] sample_in_r;
    logic                    sample_req;
    logic                    sample_end;
    logic [SAMPLE_WIDTH-1:0] audio_in_l;
    logic [SAMPLE_WIDTH-1:0] audio_in_r;

    // Serializer side: consumes DAC samples, requests them, returns ADC words
    modport master (
        input  sample_in_l,
        input  sample_in_r,
        output sample_req,
        output sample_end,
        output audio_in_l,
        output audio_in_r
    );

    // Upstream audio stage side
    modport slave (
        output sample_in_l,
        output sample_in_r,
        input  sample_req,
        input  sample_end,
        input  audio_in_l,
        input  audio_in_r
    );
endinterface

// File: rtl/audio_codec_i2s.sv
// rtl/audio_codec_i2s.sv - I2S master: BCLK/LRCK generation, DAC serializer, ADC deserializer
module audio_codec_i2s #(
    parameter int BCLK_DIV     = 8,
    parameter int SLOT_BITS    = 32,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    audio_codec_i2s_if.master smp,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_adclrck,
    output logic              aud_dacdat,
    input  logic              aud_adcdat
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam int DW         = $clog2(BCLK_DIV);
    localparam int SW         = SAMPLE_WIDTH;

    logic [DW-1:0] div_q;
    logic          bclk_q;
    logic [CW-1:0] bit_cnt_q;
    logic [CW-1:0] bit_cnt_d;
    logic          lrck_q;
    logic          dacdat_q;
    logic          sample_req_q;
    logic          sample_end_q;
    logic [SW-1:0] shift_l_q;
    logic [SW-1:0] shift_r_q;
    logic          adc_s1_q;
    logic          adc_s2_q;
    logic [1:0]    cap_l_q;
    logic [1:0]    cap_r_q;
    logic [SW-1:0] adc_l_q;
    logic [SW-1:0] adc_l_d;
    logic [SW-1:0] adc_r_q;
    logic [SW-1:0] adc_r_d;
    logic [SW-1:0] audio_l_q;
    logic [SW-1:0] audio_r_q;
    logic          div_term;
    logic          rise;
    logic          fall;
    logic          frame_start;
    logic          cur_left;
    logic          cur_right;
    logic          nxt_left;
    logic          nxt_right;

    // Event decode, next bit position and ADC word next-state
    always_comb begin
        div_term    = (div_q == DW'(BCLK_DIV - 1));
        rise        = div_term && !bclk_q;
        fall        = div_term && bclk_q;
        bit_cnt_d   = (bit_cnt_q == CW'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + CW'(1);
        frame_start = fall && (bit_cnt_d == '0);
        cur_left    = (bit_cnt_q >= CW'(1)) && (bit_cnt_q <= CW'(SW));
        cur_right   = (bit_cnt_q >= CW'(SLOT_BITS + 1)) && (bit_cnt_q <= CW'(SLOT_BITS + SW));
        nxt_left    = (bit_cnt_d >= CW'(1)) && (bit_cnt_d <= CW'(SW));
        nxt_right   = (bit_cnt_d >= CW'(SLOT_BITS + 1)) && (bit_cnt_d <= CW'(SLOT_BITS + SW));
        adc_l_d     = cap_l_q[1] ? {adc_l_q[SW-2:0], adc_s2_q} : adc_l_q;
        adc_r_d     = cap_r_q[1] ? {adc_r_q[SW-2:0], adc_s2_q} : adc_r_q;
    end

    // Bit clock divider: toggle BCLK every BCLK_DIV clks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (div_term) begin
            div_q  <= '0;
            bclk_q <= !bclk_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end

    // Frame sequencing on BCLK falls: bit counter, LRCK, DAC shift-out, req/end strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q    <= '0;
            lrck_q       <= 1'b0;
            dacdat_q     <= 1'b0;
            sample_req_q <= 1'b0;
            sample_end_q <= 1'b0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
        end else if (fall) begin
            bit_cnt_q    <= bit_cnt_d;
            lrck_q       <= (bit_cnt_d >= CW'(SLOT_BITS));
            sample_req_q <= (bit_cnt_d == CW'(FRAME_BITS - 2));
            sample_end_q <= (bit_cnt_d == '0);
            if (bit_cnt_d == '0) begin
                shift_l_q <= smp.sample_in_l;
                shift_r_q <= smp.sample_in_r;
                dacdat_q  <= 1'b0;
            end else if (nxt_left) begin
                dacdat_q  <= shift_l_q[SW-1];
                shift_l_q <= shift_l_q << 1;
            end else if (nxt_right) begin
                dacdat_q  <= shift_r_q[SW-1];
                shift_r_q <= shift_r_q << 1;
            end else begin
                dacdat_q  <= 1'b0;
            end
        end else begin
            sample_req_q <= 1'b0;
            sample_end_q <= 1'b0;
        end
    end

    // ADC capture: the rise-event strobe is delayed two clks so it meets the
    // pin value as it was at the rise after passing through the synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_s1_q  <= 1'b0;
            adc_s2_q  <= 1'b0;
            cap_l_q   <= '0;
            cap_r_q   <= '0;
            adc_l_q   <= '0;
            adc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
        end else begin
            adc_s1_q <= aud_adcdat;
            adc_s2_q <= adc_s1_q;
            cap_l_q  <= {cap_l_q[0], rise && cur_left};
            cap_r_q  <= {cap_r_q[0], rise && cur_right};
            adc_l_q  <= adc_l_d;
            adc_r_q  <= adc_r_d;
            if (frame_start) begin
                audio_l_q <= adc_l_d;
                audio_r_q <= adc_r_d;
            end
        end
    end

    assign aud_bclk       = bclk_q;
    assign aud_daclrck    = lrck_q;
    assign aud_adclrck    = lrck_q;
    assign aud_dacdat     = dacdat_q;
    assign smp.sample_req = sample_req_q;
    assign smp.sample_end = sample_end_q;
    assign smp.audio_in_l = audio_l_q;
    assign smp.audio_in_r = audio_r_q;
endmodule

// File: tb/tb_audio_codec_i2s.sv
// tb/tb_audio_codec_i2s.sv - scoreboard bench for audio_codec_i2s (default and small-parameter instances)
module tb_audio_codec_i2s;
    localparam int SW     = 16;
    localparam int A_DIV  = 8;
    localparam int A_SLOT = 32;
    localparam int B_DIV  = 2;
    localparam int B_SLOT = 17;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_a;
    logic          rst_b;
    logic          sel;
    logic          adc_drive;
    logic [SW-1:0] din_l;
    logic [SW-1:0] din_r;

    audio_codec_i2s_if #(.SAMPLE_WIDTH(SW)) ifa ();
    audio_codec_i2s_if #(.SAMPLE_WIDTH(SW)) ifb ();
    assign ifa.sample_in_l = din_l;
    assign ifa.sample_in_r = din_r;
    assign ifb.sample_in_l = din_l;
    assign ifb.sample_in_r = din_r;

    wire bclk_a, lr_a, adclr_a, dac_a;
    wire bclk_b, lr_b, adclr_b, dac_b;
    wire adc_a = sel ? 1'b0 : adc_drive;
    wire adc_b = sel ? adc_drive : 1'b0;

    audio_codec_i2s #(.BCLK_DIV(A_DIV), .SLOT_BITS(A_SLOT), .SAMPLE_WIDTH(SW)) dut_a (
        .clk(clk), .reset_n(rst_a), .smp(ifa.master),
        .aud_bclk(bclk_a), .aud_daclrck(lr_a), .aud_adclrck(adclr_a),
        .aud_dacdat(dac_a), .aud_adcdat(adc_a)
    );

    audio_codec_i2s #(.BCLK_DIV(B_DIV), .SLOT_BITS(B_SLOT), .SAMPLE_WIDTH(SW)) dut_b (
        .clk(clk), .reset_n(rst_b), .smp(ifb.master),
        .aud_bclk(bclk_b), .aud_daclrck(lr_b), .aud_adclrck(adclr_b),
        .aud_dacdat(dac_b), .aud_adcdat(adc_b)
    );

    wire          m_bclk  = sel ? bclk_b : bclk_a;
    wire          m_lr    = sel ? lr_b : lr_a;
    wire          m_adclr = sel ? adclr_b : adclr_a;
    wire          m_dac   = sel ? dac_b : dac_a;
    wire          m_req   = sel ? ifb.sample_req : ifa.sample_req;
    wire          m_end   = sel ? ifb.sample_end : ifa.sample_end;
    wire [SW-1:0] m_aud_l = sel ? ifb.audio_in_l : ifa.audio_in_l;
    wire [SW-1:0] m_aud_r = sel ? ifb.audio_in_r : ifa.audio_in_r;

    frame_t        stim_q[$];
    frame_t        exp_q[$];
    frame_t        cur;
    int            total = 0;
    int            passed = 0;
    int            fails = 0;
    bit            mon_on = 0;
    int            j;
    logic [SW-1:0] cap_l;
    logic [SW-1:0] cap_r;
    int            other_bad;
    int            lr_bad;
    logic          prev_bclk;
    int            rel_cyc;
    int            last_req;
    int            last_end;
    int            ends_seen = 0;
    bit            seen_rise;
    bit            seen_req;
    bit            seen_end;
    bit            scr_armed = 0;
    bit            scr_next = 0;
    int            slot = A_SLOT;
    int            div = A_DIV;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_data(input int k);
        return (k >= 1 && k <= SW) || (k >= slot + 1 && k <= slot + SW);
    endfunction

    task automatic record_bit();
        logic lr_exp;
        lr_exp = (j >= slot);
        if (m_lr !== lr_exp || m_adclr !== lr_exp) lr_bad++;
        if (j >= 1 && j <= SW) cap_l = {cap_l[SW-2:0], m_dac};
        else if (j >= slot + 1 && j <= slot + SW) cap_r = {cap_r[SW-2:0], m_dac};
        else if (m_dac !== 1'b0) other_bad++;
        // loop DAC data back in data bits, drive 1s elsewhere (must be ignored)
        adc_drive = in_data(j) ? m_dac : 1'b1;
    endtask

    task automatic start_frame(input frame_t f);
        cur       = f;
        j         = 0;
        cap_l     = '0;
        cap_r     = '0;
        other_bad = 0;
        lr_bad    = 0;
        record_bit();
    endtask

    task automatic finish_frame();
        chk("dac_left_word", cap_l, cur.l);
        chk("dac_right_word", cap_r, cur.r);
        chk("dac_other_bits", other_bad, 0);
        chk("lrck_pattern", lr_bad, 0);
        chk("frame_bits", j, 2 * slot - 1);
        chk("adc_left_word", m_aud_l, cur.l);
        chk("adc_right_word", m_aud_r, cur.r);
    endtask

    task automatic tick();
        frame_t nf;
        @(negedge clk);
        if (!mon_on) return;
        if (scr_next) begin
            din_l    = '1;
            din_r    = '1;
            scr_next = 0;
        end
        if (prev_bclk === 1'b1 && m_bclk === 1'b0) begin
            if (m_end) begin
                finish_frame();
                chk("scoreboard_pop", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) start_frame(exp_q.pop_front());
                else start_frame('0);
            end else begin
                j++;
                record_bit();
            end
        end
        if (!seen_rise && m_bclk === 1'b1) begin
            chk("first_bclk_rise_clk", cyc - rel_cyc, div);
            seen_rise = 1;
        end
        if (m_req) begin
            if (!seen_req) chk("first_req_clk", cyc - rel_cyc, (2 * slot - 2) * 2 * div);
            else chk("req_period", cyc - last_req, 4 * slot * div);
            seen_req = 1;
            last_req = cyc;
            if (stim_q.size() != 0) nf = stim_q.pop_front();
            else nf = '0;
            din_l = nf.l;
            din_r = nf.r;
            exp_q.push_back(nf);
        end
        if (m_end) begin
            if (!seen_end) chk("first_end_clk", cyc - rel_cyc, 4 * slot * div);
            else chk("end_period", cyc - last_end, 4 * slot * div);
            seen_end = 1;
            last_end = cyc;
            ends_seen++;
            if (scr_armed) begin
                scr_next  = 1;
                scr_armed = 0;
            end
        end
        if (m_req || m_end) chk("req_end_apart", m_req && m_end, 0);
        prev_bclk = m_bclk;
    endtask

    task automatic release_dut();
        @(negedge clk);
        if (sel) rst_b = 1'b1;
        else rst_a = 1'b1;
        slot      = sel ? B_SLOT : A_SLOT;
        div       = sel ? B_DIV : A_DIV;
        rel_cyc   = cyc;
        prev_bclk = 1'b0;
        seen_rise = 0;
        seen_req  = 0;
        seen_end  = 0;
        scr_next  = 0;
        exp_q.delete();
        mon_on    = 1;
        start_frame('0);
    endtask

    task automatic run_ends(input int n);
        int target;
        int budget;
        int guard;
        target = ends_seen + n;
        budget = (n + 1) * 4 * slot * div;
        guard  = 0;
        while (ends_seen < target && guard < budget) begin
            tick();
            guard++;
        end
        chk("frames_completed", ends_seen >= target, 1);
    endtask

    initial begin
        int guard;
        sel       = 1'b0;
        rst_a     = 1'b0;
        rst_b     = 1'b0;
        adc_drive = 1'b0;
        din_l     = '0;
        din_r     = '0;
        repeat (5) tick();

        chk("rst_bclk", m_bclk, 0);
        chk("rst_daclrck", m_lr, 0);
        chk("rst_adclrck", m_adclr, 0);
        chk("rst_dacdat", m_dac, 0);
        chk("rst_sample_req", m_req, 0);
        chk("rst_sample_end", m_end, 0);
        chk("rst_audio_in_l", m_aud_l, 0);
        chk("rst_audio_in_r", m_aud_r, 0);
        chk("rst_b_bclk", bclk_b, 0);
        chk("rst_b_dacdat", dac_b, 0);

        stim_q.push_back('{l: 16'hA5C3, r: 16'h8001});
        stim_q.push_back('{l: 16'h1234, r: 16'hFEDC});
        stim_q.push_back('{l: 16'h0F0F, r: 16'h7070});
        stim_q.push_back('{l: 16'h5A5A, r: 16'hFEDC});
        scr_armed = 1;
        release_dut();
        run_ends(4);

        guard = 0;
        while (!(j == A_SLOT + 4 && m_bclk === 1'b1) && guard < 3000) begin
            tick();
            guard++;
        end
        chk("reached_bit36", (j == A_SLOT + 4) && (m_bclk === 1'b1), 1);
        chk("pre_reset_dacdat", m_dac, 1);
        chk("pre_reset_lrck", m_lr, 1);
        rst_a  = 1'b0;
        mon_on = 0;
        #1;
        chk("async_rst_bclk", m_bclk, 0);
        chk("async_rst_daclrck", m_lr, 0);
        chk("async_rst_adclrck", m_adclr, 0);
        chk("async_rst_dacdat", m_dac, 0);
        repeat (3) tick();
        stim_q.delete();
        stim_q.push_back('{l: 16'h1357, r: 16'h2468});
        release_dut();
        run_ends(3);

        mon_on = 0;
        sel    = 1'b1;
        stim_q.delete();
        stim_q.push_back('{l: 16'hA5C3, r: 16'h8001});
        stim_q.push_back('{l: 16'h1234, r: 16'hFEDC});
        release_dut();
        run_ends(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
